rot_job_sched: RTL and testbench

Job scheduler in front of the rotation address core. Software or a config master pushes rotate jobs (height, width, direction, degrees) into a small FIFO. The scheduler validates each job, drives the core's configuration inputs stable for the job's duration, and issues a one-cycle start. It then waits for completion or a watchdog timeout and reports per-job status plus a sticky interrupt.

---
 rtl/rot_pkg.sv | 42 ++++
 rtl/rot_job_sched_if.sv | 24 ++
 rtl/rot_job_fifo.sv | 51 +++++
 rtl/rot_job_sched.sv | 137 +++++++++++++
 tb/tb_rot_job_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rot_pkg.sv
// Shared types for the rotate-job scheduler: FSM states, status codes,
// degree codes, job field limit masks and the job record.
package rot_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_START,
      S_RUN,
      S_FINISH
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_REJECT  = 2'd1,
      ST_TIMEOUT = 2'd2
   } status_t;

   localparam logic [1:0] DEG_0   = 2'd0;
   localparam logic [1:0] DEG_90  = 2'd1;
   localparam logic [1:0] DEG_180 = 2'd2;
   localparam logic [1:0] DEG_270 = 2'd3;

   localparam logic [15:0] H_LIMIT_MASK = 16'h8000;
   localparam logic [15:0] W_LIMIT_MASK = 16'hC000;

   typedef struct packed {
      logic [15:0] height;
      logic [15:0] width;
      logic        direction;
      logic [1:0]  degrees;
   } job_t;

   // A job is runnable only if both sizes are nonzero and within range.
   function automatic logic job_ok(job_t j);
      return ((j.height & H_LIMIT_MASK) == 16'd0) &&
             ((j.width & W_LIMIT_MASK) == 16'd0) &&
             (j.height != 16'd0) &&
             (j.width != 16'd0);
   endfunction

endpackage

// File: rtl/rot_job_sched_if.sv
// Job push handshake: valid/ready plus the job fields.
// master drives the job, slave (scheduler) returns ready.
interface rot_job_sched_if;

   logic        I_JOB_VALID;
   logic        O_JOB_READY;
   logic [15:0] I_JOB_HEIGHT;
   logic [15:0] I_JOB_WIDTH;
   logic        I_JOB_DIRECTION;
   logic [1:0]  I_JOB_DEGREES;

   modport master (
      output I_JOB_VALID, I_JOB_HEIGHT, I_JOB_WIDTH,
      output I_JOB_DIRECTION, I_JOB_DEGREES,
      input  O_JOB_READY
   );

   modport slave (
      input  I_JOB_VALID, I_JOB_HEIGHT, I_JOB_WIDTH,
      input  I_JOB_DIRECTION, I_JOB_DEGREES,
      output O_JOB_READY
   );

endinterface

// File: rtl/rot_job_fifo.sv
// Show-ahead job FIFO with wrap-bit pointers.
// Ports: clk, rst_n, push/wdata, pop, head, full, empty, level.
module rot_job_fifo
   import rot_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  job_t                     wdata,
   input  logic                     pop,
   output job_t                     head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   job_t          mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   // No bypass: a full FIFO drops the push even when popping.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/rot_job_sched.sv
// Rotate-job scheduler: queues jobs, validates, drives core config,
// pulses start, watches done/timeout, reports status, irq, done count.
module rot_job_sched
   import rot_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int TIMEOUT_W = 20
) (
   input  logic                   I_HCLK,
   input  logic                   I_HRESET_N,
   rot_job_sched_if.slave         job,
   output logic [15:0]            O_HEIGHT,
   output logic [15:0]            O_WIDTH,
   output logic                   O_DIRECTION,
   output logic [1:0]             O_DEGREES,
   output logic                   O_START,
   input  logic                   I_CORE_DONE,
   input  logic [TIMEOUT_W-1:0]   I_TIMEOUT_LIMIT,
   output logic                   O_BUSY,
   output logic [$clog2(DEPTH):0] O_LEVEL,
   output logic [1:0]             O_STATUS,
   output logic                   O_IRQ,
   input  logic                   I_IRQ_CLR,
   output logic [7:0]             O_DONE_COUNT
);

   localparam logic [TIMEOUT_W-1:0] WD_ONE = 1;

   state_t               state_q;
   state_t               state_d;
   status_t              pend_q;
   logic [TIMEOUT_W-1:0] wd_q;
   job_t                 head;
   job_t                 wdata;
   logic                 full;
   logic                 empty;
   logic                 pop;
   logic                 tmo;

   assign wdata = '{
      height:    job.I_JOB_HEIGHT,
      width:     job.I_JOB_WIDTH,
      direction: job.I_JOB_DIRECTION,
      degrees:   job.I_JOB_DEGREES
   };

   assign job.O_JOB_READY = !full;

   rot_job_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (I_HCLK),
      .rst_n (I_HRESET_N),
      .push  (job.I_JOB_VALID),
      .wdata (wdata),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty),
      .level (O_LEVEL)
   );

   assign tmo = (I_TIMEOUT_LIMIT != '0) &&
                ((wd_q + WD_ONE) == I_TIMEOUT_LIMIT);

   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (!empty) state_d = S_CHECK;
         S_CHECK:  state_d = job_ok(head) ? S_START : S_FINISH;
         S_START:  state_d = S_RUN;
         S_RUN:    if (I_CORE_DONE || tmo) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Decoded from the state flop only; reset drops them at once.
   always_comb begin
      pop     = 1'b0;
      O_START = 1'b0;
      O_BUSY  = (state_q != S_IDLE);
      unique case (1'b1)
         (state_q == S_CHECK): pop     = 1'b1;
         (state_q == S_START): O_START = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N) begin
         O_HEIGHT     <= '0;
         O_WIDTH      <= '0;
         O_DIRECTION  <= 1'b0;
         O_DEGREES    <= '0;
         wd_q         <= '0;
         pend_q       <= ST_OK;
         O_STATUS     <= '0;
         O_DONE_COUNT <= '0;
      end else begin
         unique case (state_q)
            S_CHECK: begin
               O_HEIGHT    <= head.height;
               O_WIDTH     <= head.width;
               O_DIRECTION <= head.direction;
               O_DEGREES   <= head.degrees;
               pend_q      <= job_ok(head) ? ST_OK : ST_REJECT;
            end
            S_START: wd_q <= '0;
            S_RUN: begin
               wd_q <= wd_q + WD_ONE;
               // Done outranks a coincident timeout.
               if (I_CORE_DONE) pend_q <= ST_OK;
               else if (tmo)    pend_q <= ST_TIMEOUT;
            end
            S_FINISH: begin
               O_STATUS <= pend_q;
               if (pend_q == ST_OK) O_DONE_COUNT <= O_DONE_COUNT + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // A set from FINISH wins over a same-cycle clear.
   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N)              O_IRQ <= 1'b0;
      else if (state_q == S_FINISH) O_IRQ <= 1'b1;
      else if (I_IRQ_CLR)           O_IRQ <= 1'b0;
   end

endmodule

// File: tb/tb_rot_job_sched.sv
// Directed testbench for rot_job_sched: valid, reject, timeout,
// FIFO full, irq collision and asynchronous reset scenarios.
module tb_rot_job_sched;

   logic        clk;
   logic        rst_n;
   logic [15:0] O_HEIGHT;
   logic [15:0] O_WIDTH;
   logic        O_DIRECTION;
   logic [1:0]  O_DEGREES;
   logic        O_START;
   logic        I_CORE_DONE;
   logic [19:0] I_TIMEOUT_LIMIT;
   logic        O_BUSY;
   logic [2:0]  O_LEVEL;
   logic [1:0]  O_STATUS;
   logic        O_IRQ;
   logic        I_IRQ_CLR;
   logic [7:0]  O_DONE_COUNT;

   int tests = 0;
   int fails = 0;
   int start_total = 0;
   int s0;
   logic [7:0] exp_cnt;

   rot_job_sched_if jif ();

   rot_job_sched #(.DEPTH(4), .TIMEOUT_W(20)) dut (
      .I_HCLK          (clk),
      .I_HRESET_N      (rst_n),
      .job             (jif),
      .O_HEIGHT        (O_HEIGHT),
      .O_WIDTH         (O_WIDTH),
      .O_DIRECTION     (O_DIRECTION),
      .O_DEGREES       (O_DEGREES),
      .O_START         (O_START),
      .I_CORE_DONE     (I_CORE_DONE),
      .I_TIMEOUT_LIMIT (I_TIMEOUT_LIMIT),
      .O_BUSY          (O_BUSY),
      .O_LEVEL         (O_LEVEL),
      .O_STATUS        (O_STATUS),
      .O_IRQ           (O_IRQ),
      .I_IRQ_CLR       (I_IRQ_CLR),
      .O_DONE_COUNT    (O_DONE_COUNT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (O_START) start_total++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_job(input logic [15:0] h, input logic [15:0] w,
                           input logic d, input logic [1:0] g);
      jif.I_JOB_VALID     = 1'b1;
      jif.I_JOB_HEIGHT    = h;
      jif.I_JOB_WIDTH     = w;
      jif.I_JOB_DIRECTION = d;
      jif.I_JOB_DEGREES   = g;
      tick();
      jif.I_JOB_VALID = 1'b0;
   endtask

   task automatic pulse_done();
      I_CORE_DONE = 1'b1;
      tick();
      I_CORE_DONE = 1'b0;
   endtask

   task automatic clr_irq();
      I_IRQ_CLR = 1'b1;
      tick();
      I_IRQ_CLR = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests++;
      if (O_LEVEL !== 3'd0 || jif.O_JOB_READY !== 1'b1) begin
         fails++;
         $display("FAIL reset_fifo level=%0d ready=%b want 0/1",
                  O_LEVEL, jif.O_JOB_READY);
      end
      tests++;
      if (O_START !== 1'b0 || O_BUSY !== 1'b0 || O_IRQ !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctl start=%b busy=%b irq=%b want 0",
                  O_START, O_BUSY, O_IRQ);
      end
      tests++;
      if (O_STATUS !== 2'd0 || O_DONE_COUNT !== 8'd0 ||
          O_HEIGHT !== 16'd0 || O_WIDTH !== 16'd0) begin
         fails++;
         $display("FAIL reset_regs st=%0d cnt=%0d h=%0d w=%0d want 0",
                  O_STATUS, O_DONE_COUNT, O_HEIGHT, O_WIDTH);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_valid_job();
      s0 = start_total;
      push_job(16'd64, 16'd32, 1'b1, 2'd1);
      tests++;
      if (O_LEVEL !== 3'd1) begin
         fails++;
         $display("FAIL valid_level got %0d want 1", O_LEVEL);
      end
      tick();
      tests++;
      if (O_BUSY !== 1'b1 || O_START !== 1'b0) begin
         fails++;
         $display("FAIL valid_check busy=%b start=%b want 1/0",
                  O_BUSY, O_START);
      end
      tick();
      tests++;
      if (O_START !== 1'b1 || O_LEVEL !== 3'd0) begin
         fails++;
         $display("FAIL valid_start start=%b level=%0d want 1/0",
                  O_START, O_LEVEL);
      end
      tests++;
      if (O_HEIGHT !== 16'd64 || O_WIDTH !== 16'd32 ||
          O_DIRECTION !== 1'b1 || O_DEGREES !== 2'd1) begin
         fails++;
         $display("FAIL valid_cfg %0d/%0d/%b/%0d want 64/32/1/1",
                  O_HEIGHT, O_WIDTH, O_DIRECTION, O_DEGREES);
      end
      tick();
      repeat (9) tick();
      pulse_done();
      tests++;
      if (O_IRQ !== 1'b0 || O_BUSY !== 1'b1) begin
         fails++;
         $display("FAIL valid_finish irq=%b busy=%b want 0/1",
                  O_IRQ, O_BUSY);
      end
      tick();
      exp_cnt = 8'd1;
      tests++;
      if (O_STATUS !== 2'd0 || O_IRQ !== 1'b1 ||
          O_DONE_COUNT !== exp_cnt || O_BUSY !== 1'b0) begin
         fails++;
         $display("FAIL valid_result st=%0d irq=%b cnt=%0d busy=%b want 0/1/%0d/0",
                  O_STATUS, O_IRQ, O_DONE_COUNT, O_BUSY, exp_cnt);
      end
      tests++;
      if (start_total - s0 !== 1) begin
         fails++;
         $display("FAIL valid_pulses got %0d want 1", start_total - s0);
      end
   endtask

   task automatic test_reject();
      logic [15:0] hv [3];
      logic [15:0] wv [3];
      hv = '{16'h8000, 16'd64, 16'd64};
      wv = '{16'd32, 16'h4000, 16'd0};
      for (int i = 0; i < 3; i++) begin
         clr_irq();
         s0 = start_total;
         push_job(hv[i], wv[i], 1'b0, 2'd2);
         repeat (3) tick();
         tests++;
         if (O_STATUS !== 2'd1 || O_IRQ !== 1'b1 ||
             O_DONE_COUNT !== exp_cnt || start_total != s0 ||
             O_BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reject_%0d st=%0d irq=%b cnt=%0d starts=%0d busy=%b want 1/1/%0d/0/0",
                     i, O_STATUS, O_IRQ, O_DONE_COUNT, start_total - s0,
                     O_BUSY, exp_cnt);
         end
      end
   endtask

   task automatic test_timeout();
      clr_irq();
      I_TIMEOUT_LIMIT = 20'd16;
      push_job(16'd100, 16'd200, 1'b0, 2'd2);
      repeat (3) tick();
      repeat (16) tick();
      tests++;
      if (O_IRQ !== 1'b0 || O_BUSY !== 1'b1 || O_STATUS !== 2'd1) begin
         fails++;
         $display("FAIL timeout_early irq=%b busy=%b st=%0d want 0/1/1",
                  O_IRQ, O_BUSY, O_STATUS);
      end
      tick();
      tests++;
      if (O_STATUS !== 2'd2 || O_IRQ !== 1'b1 ||
          O_DONE_COUNT !== exp_cnt) begin
         fails++;
         $display("FAIL timeout_result st=%0d irq=%b cnt=%0d want 2/1/%0d",
                  O_STATUS, O_IRQ, O_DONE_COUNT, exp_cnt);
      end
      tests++;
      if (O_HEIGHT !== 16'd100 || O_WIDTH !== 16'd200 ||
          O_DIRECTION !== 1'b0 || O_DEGREES !== 2'd2) begin
         fails++;
         $display("FAIL timeout_cfg %0d/%0d/%b/%0d want 100/200/0/2",
                  O_HEIGHT, O_WIDTH, O_DIRECTION, O_DEGREES);
      end
      clr_irq();
      I_TIMEOUT_LIMIT = 20'd0;
      push_job(16'd8, 16'd8, 1'b1, 2'd3);
      repeat (300) tick();
      tests++;
      if (O_BUSY !== 1'b1 || O_IRQ !== 1'b0) begin
         fails++;
         $display("FAIL nolimit_wait busy=%b irq=%b want 1/0",
                  O_BUSY, O_IRQ);
      end
      pulse_done();
      tick();
      exp_cnt = exp_cnt + 8'd1;
      tests++;
      if (O_STATUS !== 2'd0 || O_DONE_COUNT !== exp_cnt) begin
         fails++;
         $display("FAIL nolimit_done st=%0d cnt=%0d want 0/%0d",
                  O_STATUS, O_DONE_COUNT, exp_cnt);
      end
      pulse_done();
      tick();
      tests++;
      if (O_DONE_COUNT !== exp_cnt || O_BUSY !== 1'b0) begin
         fails++;
         $display("FAIL idle_done cnt=%0d busy=%b want %0d/0",
                  O_DONE_COUNT, O_BUSY, exp_cnt);
      end
   endtask

   task automatic test_fifo_full();
      int c;
      push_job(16'd10, 16'd10, 1'b0, 2'd0);
      repeat (3) tick();
      s0 = start_total;
      jif.I_JOB_VALID     = 1'b1;
      jif.I_JOB_WIDTH     = 16'd5;
      jif.I_JOB_DIRECTION = 1'b1;
      jif.I_JOB_DEGREES   = 2'd0;
      for (int k = 0; k < 5; k++) begin
         jif.I_JOB_HEIGHT = 16'd11 + 16'(k);
         tick();
      end
      jif.I_JOB_VALID = 1'b0;
      tests++;
      if (O_LEVEL !== 3'd4 || jif.O_JOB_READY !== 1'b0) begin
         fails++;
         $display("FAIL full_level level=%0d ready=%b want 4/0",
                  O_LEVEL, jif.O_JOB_READY);
      end
      pulse_done();
      exp_cnt = exp_cnt + 8'd1;
      for (int j = 1; j <= 4; j++) begin
         c = 0;
         while (!O_START && c < 20) begin
            tick();
            c++;
         end
         tests++;
         if (O_START !== 1'b1 || O_HEIGHT !== 16'd10 + 16'(j)) begin
            fails++;
            $display("FAIL full_order_%0d start=%b h=%0d want 1/%0d",
                     j, O_START, O_HEIGHT, 10 + j);
         end
         tick();
         pulse_done();
         exp_cnt = exp_cnt + 8'd1;
      end
      repeat (8) tick();
      tests++;
      if (O_LEVEL !== 3'd0 || O_BUSY !== 1'b0 ||
          O_DONE_COUNT !== exp_cnt || start_total - s0 != 4) begin
         fails++;
         $display("FAIL full_drain level=%0d busy=%b cnt=%0d starts=%0d want 0/0/%0d/4",
                  O_LEVEL, O_BUSY, O_DONE_COUNT, start_total - s0, exp_cnt);
      end
   endtask

   task automatic test_irq_collision();
      clr_irq();
      push_job(16'd3, 16'd4, 1'b0, 2'd1);
      repeat (3) tick();
      pulse_done();
      clr_irq();
      exp_cnt = exp_cnt + 8'd1;
      tests++;
      if (O_IRQ !== 1'b1 || O_STATUS !== 2'd0) begin
         fails++;
         $display("FAIL irq_collision irq=%b st=%0d want 1/0",
                  O_IRQ, O_STATUS);
      end
      clr_irq();
      tests++;
      if (O_IRQ !== 1'b0) begin
         fails++;
         $display("FAIL irq_clear got %b want 0", O_IRQ);
      end
   endtask

   task automatic test_reset_mid_run();
      push_job(16'd20, 16'd30, 1'b1, 2'd3);
      push_job(16'd21, 16'd31, 1'b0, 2'd2);
      tick();
      tests++;
      if (O_START !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre_start got %b want 1", O_START);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (O_START !== 1'b0 || O_BUSY !== 1'b0 || O_LEVEL !== 3'd0 ||
          jif.O_JOB_READY !== 1'b1) begin
         fails++;
         $display("FAIL rst_async_ctl start=%b busy=%b level=%0d ready=%b want 0/0/0/1",
                  O_START, O_BUSY, O_LEVEL, jif.O_JOB_READY);
      end
      tests++;
      if (O_HEIGHT !== 16'd0 || O_DONE_COUNT !== 8'd0 ||
          O_STATUS !== 2'd0 || O_IRQ !== 1'b0) begin
         fails++;
         $display("FAIL rst_async_regs h=%0d cnt=%0d st=%0d irq=%b want 0",
                  O_HEIGHT, O_DONE_COUNT, O_STATUS, O_IRQ);
      end
      #2;
      rst_n = 1'b1;
      tick();
      s0 = start_total;
      push_job(16'd7, 16'd9, 1'b1, 2'd0);
      repeat (3) tick();
      pulse_done();
      tick();
      repeat (4) tick();
      tests++;
      if (O_STATUS !== 2'd0 || O_DONE_COUNT !== 8'd1 ||
          O_IRQ !== 1'b1 || O_HEIGHT !== 16'd7 || start_total - s0 != 1) begin
         fails++;
         $display("FAIL rst_next_job st=%0d cnt=%0d irq=%b h=%0d starts=%0d want 0/1/1/7/1",
                  O_STATUS, O_DONE_COUNT, O_IRQ, O_HEIGHT, start_total - s0);
      end
   endtask

   initial begin
      jif.I_JOB_VALID     = 1'b0;
      jif.I_JOB_HEIGHT    = '0;
      jif.I_JOB_WIDTH     = '0;
      jif.I_JOB_DIRECTION = 1'b0;
      jif.I_JOB_DEGREES   = '0;
      I_CORE_DONE         = 1'b0;
      I_IRQ_CLR           = 1'b0;
      I_TIMEOUT_LIMIT     = '0;
      rst_n               = 1'b1;
      exp_cnt             = 8'd0;
      #3;
      test_reset();
      test_valid_job();
      test_reject();
      test_timeout();
      test_fifo_full();
      test_irq_collision();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
